softmc_host_bridge: RTL

- Host-side counterpart of the softMC app command and readback interfaces.
- Accepts 32-bit instruction words from a host stream and issues them on app_en/app_instr under the app_ack handshake, respecting iq_full.
- Drains the readback FIFO (standard-read, 1-cycle dout latency) and serializes each 4*DQ_WIDTH-bit entry into HOST_WIDTH-bit host words, lowest slice first.
- Sits between the host transport (PCIe/UART glue) and the softMC top.

---
 rtl/softmc_host_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/softmc_host_bridge.sv
// Host-side bridge for softMC: streams host instruction words onto the
// app command port and serializes readback FIFO entries into host words.
module softmc_host_bridge #(
  parameter int TCQ        = 100,
  parameter int DQ_WIDTH   = 64,
  parameter int HOST_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    host_instr_valid,
  input  logic [31:0]             host_instr,
  output logic                    host_instr_ready,
  output logic                    app_en,
  output logic [31:0]             app_instr,
  input  logic                    app_ack,
  input  logic                    iq_full,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_data,
  output logic                    host_rd_valid,
  output logic [HOST_WIDTH-1:0]   host_rd_data,
  input  logic                    host_rd_ready,
  output logic [CNT_WIDTH-1:0]    instr_sent_cnt,
  output logic [CNT_WIDTH-1:0]    rd_entries_cnt,
  output logic                    busy
);

  localparam int EW = 4 * DQ_WIDTH;
  localparam int NW = EW / HOST_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_SEND
  } rd_state_e;

  logic                 app_en_q, app_en_d;
  logic [31:0]          app_instr_q, app_instr_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic                 app_xfer, host_xfer;

  rd_state_e            rd_state_q, rd_state_d;
  logic [EW-1:0]        sh_q, sh_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] ent_cnt_q, ent_cnt_d;
  logic                 rden;

  // The slot frees up on ack, so a new word can ride the same edge.
  assign host_instr_ready = rst_n & (~app_en_q | app_ack) & ~iq_full;
  assign host_xfer = host_instr_valid & host_instr_ready;
  assign app_xfer  = app_en_q & app_ack;

  always_comb begin
    app_en_d    = app_en_q;
    app_instr_d = app_instr_q;
    instr_cnt_d = instr_cnt_q;
    if (app_xfer) begin
      app_en_d    = 1'b0;
      instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
    end
    if (host_xfer) begin
      app_en_d    = 1'b1;
      app_instr_d = host_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      app_en_q    <= 1'b0;
      app_instr_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      app_en_q    <= app_en_d;
      app_instr_q <= app_instr_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      sh_q       <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      ent_cnt_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      ent_cnt_q  <= ent_cnt_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (!rdback_fifo_empty) rd_state_d = RD_WAIT;
      RD_WAIT: rd_state_d = RD_SEND;
      RD_SEND: begin
        if (rd_valid_q && host_rd_ready && idx_q == LAST)
          rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Low slice of the shift register is always the word on offer.
  always_comb begin
    rden       = 1'b0;
    sh_d       = sh_q;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q;
    ent_cnt_d  = ent_cnt_q;
    unique case (rd_state_q)
      RD_IDLE: rden = ~rdback_fifo_empty;
      RD_WAIT: begin
        sh_d       = rdback_data;
        idx_d      = '0;
        rd_valid_d = 1'b1;
      end
      RD_SEND: begin
        if (rd_valid_q && host_rd_ready) begin
          if (idx_q == LAST) begin
            rd_valid_d = 1'b0;
            ent_cnt_d  = ent_cnt_q + CNT_WIDTH'(1);
          end else begin
            idx_d = idx_q + IW'(1);
            sh_d  = sh_q >> HOST_WIDTH;
          end
        end
      end
      default: ;
    endcase
  end

  assign rdback_fifo_rden = rden & rst_n;
  assign app_en           = app_en_q;
  assign app_instr        = app_instr_q;
  assign instr_sent_cnt   = instr_cnt_q;
  assign host_rd_valid    = rd_valid_q;
  assign host_rd_data     = sh_q[HOST_WIDTH-1:0];
  assign rd_entries_cnt   = ent_cnt_q;
  assign busy             = app_en_q | (rd_state_q != RD_IDLE);

endmodule
